// File: rtl/pinfilter_pkg.sv
// -----------------------------------------------------------------------------
// pinfilter_pkg
// Shared definitions for the pin-filter scheduler:
//   NPINS_DEF / DIV_W_DEF : default pin count and sample-divider width
//   arb_state_t           : event arbiter state encoding (IDLE=0, PRESENT=1)
//   idx_w()               : width of a pin index, never less than one bit
// -----------------------------------------------------------------------------
package pinfilter_pkg;

   localparam int NPINS_DEF = 8;
   localparam int DIV_W_DEF = 8;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } arb_state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pinfilter.sv
// -----------------------------------------------------------------------------
// pinfilter
// Two-sample-agreement glitch filter for one GPIO line. On every strobe the
// raw line is sampled; the output level only follows the line once two
// consecutive strobes have seen the same value, otherwise it holds.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset (sample and level go high)
//   ena     : sample strobe
//   din     : raw line
//   level   : filtered level
// -----------------------------------------------------------------------------
module pinfilter (
   input  logic clk,
   input  logic reset_n,
   input  logic ena,
   input  logic din,
   output logic level
);

   logic smp_p0;

   // stage p0: previous strobe sample; level updates on agreement
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         smp_p0 <= 1'b1;
         level  <= 1'b1;
      end else if (ena) begin
         smp_p0 <= din;
         if (din == smp_p0)
            level <= din;
      end
   end

endmodule

// File: rtl/pinfilter_rr_pick.sv
// -----------------------------------------------------------------------------
// pinfilter_rr_pick
// Combinational round-robin picker: returns the first set pending bit at or
// above rr, wrapping to the lowest set bit when none is found above.
// Ports:
//   pending : pending-event bitmap
//   rr      : round-robin start position
//   hit     : any bit of pending is set
//   idx     : chosen pin index (0 when hit is low)
// -----------------------------------------------------------------------------
module pinfilter_rr_pick
   import pinfilter_pkg::*;
#(
   parameter  int NPINS = NPINS_DEF,
   localparam int IW    = idx_w(NPINS)
) (
   input  logic [NPINS-1:0] pending,
   input  logic [IW-1:0]    rr,
   output logic             hit,
   output logic [IW-1:0]    idx
);

   logic          hi_hit;
   logic          lo_hit;
   logic [IW-1:0] hi_idx;
   logic [IW-1:0] lo_idx;

   // Scanning downwards lets the lowest qualifying index win; hi_* covers
   // the positions at or above rr, lo_* the wrap-around fallback.
   always_comb begin
      hi_hit = 1'b0;
      lo_hit = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = NPINS - 1; i >= 0; i--) begin
         if (pending[i]) begin
            lo_hit = 1'b1;
            lo_idx = IW'(i);
            if (IW'(i) >= rr) begin
               hi_hit = 1'b1;
               hi_idx = IW'(i);
            end
         end
      end
      hit = lo_hit;
      idx = hi_hit ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/pinfilter_sched.sv
// -----------------------------------------------------------------------------
// pinfilter_sched
// Filters NPINS raw GPIO lines with a shared sample prescaler, detects level
// changes on the filtered lines and delivers them one at a time as
// round-robin arbitrated edge events over a valid/ack handshake.
// Optional feature: define PINFILTER_SCHED_OVF_EN to build the sticky
// lost-event flag; without it ovf is constant 0 and ovf_clr is ignored.
// Ports:
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   din       : raw GPIO lines
//   enable    : 1 runs the prescaler, 0 freezes the filters
//   div       : sample period is div+1 clocks
//   pins      : filtered line levels
//   evt_valid : an edge event is presented
//   evt_idx   : pin index of the presented event
//   evt_level : new filtered level of that pin
//   evt_ack   : accepts the presented event
//   ovf       : sticky lost-event flag
//   ovf_clr   : clears ovf
// -----------------------------------------------------------------------------
module pinfilter_sched
   import pinfilter_pkg::*;
#(
   parameter  int NPINS = NPINS_DEF,
   parameter  int DIV_W = DIV_W_DEF,
   localparam int IW    = idx_w(NPINS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NPINS-1:0] din,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   output logic [NPINS-1:0] pins,
   output logic             evt_valid,
   output logic [IW-1:0]    evt_idx,
   output logic             evt_level,
   input  logic             evt_ack,
   output logic             ovf,
   input  logic             ovf_clr
);

   logic [DIV_W-1:0] cnt;
   logic             ena;
   logic [NPINS-1:0] prev;
   logic [NPINS-1:0] edges;
   logic [NPINS-1:0] pending;
   logic [NPINS-1:0] lvl;
   logic [NPINS-1:0] clr;
   logic [IW-1:0]    rr;
   logic             hit;
   logic [IW-1:0]    pick_idx;
   arb_state_t       state;

   // Prescaler: >= compare so a div lowered below cnt fires at once
   assign ena = enable && (cnt >= div);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (!enable)
         cnt <= '0;
      else if (cnt >= div)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   // Filter stage: one agreement filter per line
   for (genvar g = 0; g < NPINS; g++) begin : g_filt
      pinfilter u_filt (
         .clk     (clk),
         .reset_n (reset_n),
         .ena     (ena),
         .din     (din[g]),
         .level   (pins[g])
      );
   end

   // Edge detect / pending stage
   assign edges = pins ^ prev;

   pinfilter_rr_pick #(.NPINS(NPINS)) u_pick (
      .pending (pending),
      .rr      (rr),
      .hit     (hit),
      .idx     (pick_idx)
   );

   always_comb begin
      clr = '0;
      if (state == IDLE && hit)
         clr[pick_idx] = 1'b1;
   end

   // A fresh edge is ORed in after the clear, so it survives a same-cycle pick
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev    <= '1;
         pending <= '0;
         lvl     <= '0;
      end else begin
         prev    <= pins;
         pending <= (pending & ~clr) | edges;
         lvl     <= (lvl & ~edges) | (pins & edges);
      end
   end

   // Arbiter stage: registered event presentation
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         rr        <= '0;
         evt_valid <= 1'b0;
         evt_idx   <= '0;
         evt_level <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (hit) begin
                  evt_idx   <= pick_idx;
                  evt_level <= lvl[pick_idx];
                  evt_valid <= 1'b1;
                  state     <= PRESENT;
               end
            end
            PRESENT: begin
               if (evt_ack) begin
                  evt_valid <= 1'b0;
                  rr        <= (evt_idx == IW'(NPINS - 1)) ? '0 : evt_idx + 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PINFILTER_SCHED_OVF_EN
   // A lost event is an edge on a pin still waiting in pending; the bit
   // being handed to the arbiter this cycle does not count.
   logic lost;
   assign lost = |(edges & pending & ~clr);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ovf <= 1'b0;
      else if (lost)
         ovf <= 1'b1;
      else if (ovf_clr)
         ovf <= 1'b0;
   end
`else
   logic unused_ovf_clr;
   assign unused_ovf_clr = ovf_clr;
   assign ovf            = 1'b0;
`endif

endmodule
